uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
Serial transmitter driven by the oversampling tick from the mod-M tick counter that sits directly upstream. That counter's complete_tick output connects to s_tick here. The block accepts one parallel word via a start strobe and shifts out a UART frame: start bit, DBIT data bits LSB first, an optional parity bit, then a stop period. It reports busy while a frame is in progress and issues a one-clock done tick when the frame ends.

Parameters:
DBIT, 8, number of data bits per frame (5..9)
OS, 16, s_tick periods per start, data and parity bit
SB_TICK, 16, s_tick periods for the stop period (16/24/32 = 1/1.5/2 stop bits at OS=16)
PARITY_EN, 0, 1 inserts a parity bit after the data bits
PARITY_ODD, 0, parity sense when enabled: 0 = even, 1 = odd

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
s_tick  input  1  oversampling enable, one clk wide, from the upstream tick counter
tx_start  input  1  start request; sampled only while idle
din  input  DBIT  data word, latched on acceptance
busy  output  1  high while state != IDLE
tx_done_tick  output  1  one-clk pulse at end of frame
tx  output  1  serial line, registered, idles high

Behaviour:
- Reset (rst=0, async): state=IDLE, tx=1, busy=0, tx_done_tick=0, tick counter s=0, bit counter n=0, shift register cleared. Reset takes effect immediately, including mid-frame. No done tick is issued for an aborted frame.
- States: IDLE, START, DATA, PARITY, STOP. tx is registered from the next-state value, so it changes on the same edge as the state.
- IDLE: s_tick ignored. If tx_start=1 at a rising edge:
  - latch din into the shift register
  - compute par = XOR(din) ^ PARITY_ODD
  - s=0, go to START, tx falls on that edge.
- START: tx=0. On s_tick: if s==OS-1 then s=0, n=0, go to DATA; else s++.
- DATA: tx=shift[0]. On s_tick with s==OS-1: shift right, s=0.
  - if n==DBIT-1, go to PARITY when PARITY_EN=1, otherwise STOP
  - else n++
- PARITY: tx=par. On s_tick: s==OS-1 -> s=0, go to STOP; else s++.
- STOP: tx=1. On s_tick: s==SB_TICK-1 -> go to IDLE and assert tx_done_tick on that edge; else s++.
- tx_done_tick is registered and high for exactly the first IDLE cycle. tx_start in that same cycle is accepted, so back-to-back frames have a one-clk gap.
- tx_start while not IDLE is ignored; no queuing. din changes mid-frame have no effect.
- Frame length: OS*(1+DBIT+PARITY_EN)+SB_TICK s_tick periods, plus 1 clk from acceptance.
- Counter widths: s is clog2(max(OS,SB_TICK)) bits; n is clog2(DBIT) bits (minimum 1). No wrap occurs beyond the compare values.
- s_tick coincident with acceptance is not counted toward the start bit.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding localparams (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4; 3 bits)
  - default DBIT/OS/SB_TICK constants, reused by the future uart_rx.
- No sub-module inside uart_tx. The upstream tick counter is instantiated beside it at the top level, with M = clk/(baud*OS), and is not embedded here.

Test Plan:
- Reset: hold rst=0 for 5 clks with tx_start=1 -> tx=1, busy=0, tx_done_tick=0 throughout. Release rst: the request is accepted on the next edge.
- Basic frame: s_tick every 4 clks, din=8'hA5, PARITY_EN=0.
  - Mid-bit samples of tx: 0, 1,0,1,0,0,1,0,1, 1.
  - busy high for 160 ticks plus 1 clk.
  - Exactly one tx_done_tick.
- Parity: PARITY_EN=1, din=8'h07.
  - Even sense -> parity bit 1; PARITY_ODD=1 -> parity bit 0.
  - Frame is 176 ticks.
- Ignored start: tx_start=1 with din=8'hFF during data bit 2 of an 8'h3C frame -> transmitted bits remain 0,0,1,1,1,1,0,0 and no second frame follows.
- Abort: rst=0 during data bit 3 -> tx=1 and busy=0 in the same cycle, no done tick. Next request with din=8'h55 completes a correct full frame.
- Back-to-back: tx_start held high with din=8'h01 then 8'h80 -> second start bit falls exactly 1 clk after the first frame's done cycle, and the second frame carries 8'h80.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default frame constants and a counter-width helper.
package uart_pkg;

    localparam int unsigned UART_DBIT    = 8;
    localparam int unsigned UART_OS      = 16;
    localparam int unsigned UART_SB_TICK = 16;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB first, optional parity, stop period,
// paced by an external oversampling tick.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DBIT       = UART_DBIT,
    parameter int unsigned OS         = UART_OS,
    parameter int unsigned SB_TICK    = UART_SB_TICK,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_tick,
    input  logic            tx_start,
    input  logic [DBIT-1:0] din,
    output logic            busy,
    output logic            tx_done_tick,
    output logic            tx
);

    localparam int unsigned S_MAX = (OS > SB_TICK) ? OS : SB_TICK;
    localparam int unsigned S_W   = cnt_w(S_MAX);
    localparam int unsigned N_W   = cnt_w(DBIT);

    localparam logic [S_W-1:0] S_BIT_LAST  = S_W'(OS - 1);
    localparam logic [S_W-1:0] S_STOP_LAST = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_LAST      = N_W'(DBIT - 1);

    uart_state_e     r_state, w_state_nxt;
    logic [S_W-1:0]  r_s, w_s_nxt;
    logic [N_W-1:0]  r_n, w_n_nxt;
    logic [DBIT-1:0] r_shift, w_shift_nxt;
    logic            r_par, w_par_nxt;
    logic            r_tx, w_tx_nxt;
    logic            r_busy;
    logic            r_done, w_done_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_s     <= w_s_nxt;
            r_n     <= w_n_nxt;
            r_shift <= w_shift_nxt;
            r_par   <= w_par_nxt;
            r_tx    <= w_tx_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_n_nxt     = r_n;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_done_nxt  = 1'b0;
        w_tx_nxt    = 1'b1;

        case (r_state)
            ST_IDLE: begin
                // A tick coincident with acceptance is not part of the start bit.
                if (tx_start) begin
                    w_shift_nxt = din;
                    w_par_nxt   = (^din) ^ PARITY_ODD;
                    w_s_nxt     = '0;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (r_s == S_BIT_LAST) begin
                        w_s_nxt     = '0;
                        w_n_nxt     = '0;
                        w_state_nxt = ST_DATA;
                    end else begin
                        w_s_nxt = r_s + S_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (r_s == S_BIT_LAST) begin
                        w_shift_nxt = {1'b0, r_shift[DBIT-1:1]};
                        w_s_nxt     = '0;
                        if (r_n == N_LAST) begin
                            w_state_nxt = PARITY_EN ? ST_PARITY : ST_STOP;
                        end else begin
                            w_n_nxt = r_n + N_W'(1);
                        end
                    end else begin
                        w_s_nxt = r_s + S_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (s_tick) begin
                    if (r_s == S_BIT_LAST) begin
                        w_s_nxt     = '0;
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_s_nxt = r_s + S_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (s_tick) begin
                    if (r_s == S_STOP_LAST) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_s_nxt = r_s + S_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Line level follows the state being entered so tx moves with the state edge.
        case (w_state_nxt)
            ST_START:  w_tx_nxt = 1'b0;
            ST_DATA:   w_tx_nxt = w_shift_nxt[0];
            ST_PARITY: w_tx_nxt = w_par_nxt;
            default:   w_tx_nxt = 1'b1;
        endcase
    end

    assign tx           = r_tx;
    assign busy         = r_busy;
    assign tx_done_tick = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: three instances (no parity, even, odd) against a
// tick-count frame model, plus directed frames with hand-computed bit patterns.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int OS = UART_OS;
    localparam int SB = UART_SB_TICK;
    localparam int DB = UART_DBIT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_tick = 1'b0;
    logic [2:0] tx_start = 3'b000;
    logic [7:0] din = 8'h00;
    logic [2:0] busy_v, done_v, tx_v;
    logic       last_tick = 1'b0;
    bit         cmp_en = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx #(.DBIT(DB), .OS(OS), .SB_TICK(SB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_np (
        .clk(clk), .rst(rst), .s_tick(s_tick), .tx_start(tx_start[0]), .din(din),
        .busy(busy_v[0]), .tx_done_tick(done_v[0]), .tx(tx_v[0]));
    uart_tx #(.DBIT(DB), .OS(OS), .SB_TICK(SB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_pe (
        .clk(clk), .rst(rst), .s_tick(s_tick), .tx_start(tx_start[1]), .din(din),
        .busy(busy_v[1]), .tx_done_tick(done_v[1]), .tx(tx_v[1]));
    uart_tx #(.DBIT(DB), .OS(OS), .SB_TICK(SB), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_po (
        .clk(clk), .rst(rst), .s_tick(s_tick), .tx_start(tx_start[2]), .din(din),
        .busy(busy_v[2]), .tx_done_tick(done_v[2]), .tx(tx_v[2]));

    // s_tick: one clk wide, every 4th clk, changed away from the active edge
    initial begin
        int tcnt = 0;
        forever begin
            @(negedge clk);
            tcnt++;
            s_tick = ((tcnt % 4) == 0);
        end
    end

    always @(posedge clk) last_tick <= s_tick;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit pe_of(input int i);
        return (i != 0);
    endfunction

    function automatic bit po_of(input int i);
        return (i == 2);
    endfunction

    // Frame model: ticks consumed since acceptance decide the line level
    bit       m_act[3]  = '{0, 0, 0};
    bit       m_done[3] = '{0, 0, 0};
    int       m_k[3]    = '{0, 0, 0};
    logic [7:0] m_d[3]  = '{8'h00, 8'h00, 8'h00};

    function automatic int total_ticks(input int i);
        return OS * (1 + DB + int'(pe_of(i))) + SB;
    endfunction

    function automatic logic exp_tx(input int i);
        int ph;
        if (!m_act[i]) return 1'b1;
        ph = m_k[i] / OS;
        if (ph == 0) return 1'b0;
        if (ph <= DB) return m_d[i][ph-1];
        if (pe_of(i) && ph == DB + 1) return (^m_d[i]) ^ po_of(i);
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                m_act[i]  = 1'b0;
                m_done[i] = 1'b0;
                m_k[i]    = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                m_done[i] = 1'b0;
                if (m_act[i]) begin
                    if (s_tick) begin
                        m_k[i]++;
                        if (m_k[i] == total_ticks(i)) begin
                            m_act[i]  = 1'b0;
                            m_done[i] = 1'b1;
                        end
                    end
                end else if (tx_start[i]) begin
                    m_act[i] = 1'b1;
                    m_k[i]   = 0;
                    m_d[i]   = din;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("model_tx[%0d]", i),   32'(tx_v[i]),   32'(exp_tx(i)));
                chk($sformatf("model_busy[%0d]", i), 32'(busy_v[i]), 32'(m_act[i]));
                chk($sformatf("model_done[%0d]", i), 32'(done_v[i]), 32'(m_done[i]));
            end
        end
    end

    // Called at the first negedge after acceptance; samples mid-bit levels until busy drops.
    task automatic run_frame(input int inst, input bit keep, input int inj_k, input int abort_k,
                             output logic [10:0] bits, output int ticks, output int dones,
                             output bit aborted);
        int k = 0;
        int inj_state = 0;
        bits = '0;
        dones = 0;
        aborted = 1'b0;
        if (!keep) tx_start[inst] = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (inj_state == 1) begin
                tx_start[inst] = 1'b0;
                inj_state = 2;
            end
            if (last_tick) begin
                k++;
                for (int b = 0; b < 11; b++)
                    if (k == OS * b + OS / 2) bits[b] = tx_v[inst];
            end
            if (done_v[inst]) dones++;
            if (inj_k >= 0 && k == inj_k && inj_state == 0) begin
                din = 8'hFF;
                tx_start[inst] = 1'b1;
                inj_state = 1;
            end
            if (abort_k >= 0 && k == abort_k) begin
                #2 rst = 1'b0;
                #1;
                chk("abort_tx", 32'(tx_v[inst]), 32'd1);
                chk("abort_busy", 32'(busy_v[inst]), 32'd0);
                aborted = 1'b1;
                ticks = k;
                return;
            end
            if (!busy_v[inst]) begin
                ticks = k;
                return;
            end
        end
        chk("frame_timeout", 32'd1, 32'd0);
        ticks = k;
    endtask

    task automatic start_frame(input int inst, input logic [7:0] d);
        @(negedge clk);
        din = d;
        tx_start[inst] = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] bits;
        int ticks, dones, bcnt;
        bit aborted;

        #2 rst = 1'b0;
        #1 cmp_en = 1'b1;

        // Reset held with a pending request
        din = 8'hA5;
        tx_start[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_tx", 32'(tx_v[0]), 32'd1);
            chk("rst_busy", 32'(busy_v[0]), 32'd0);
            chk("rst_done", 32'(done_v[0]), 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("accept_busy", 32'(busy_v[0]), 32'd1);
        chk("accept_tx", 32'(tx_v[0]), 32'd0);

        // Basic frame 8'hA5: 0,1,0,1,0,0,1,0,1,1
        run_frame(0, 1'b0, -1, -1, bits, ticks, dones, aborted);
        chk("a5_bits", 32'(bits[9:0]), 32'h34A);
        chk("a5_ticks", 32'(ticks), 32'd160);
        chk("a5_done", 32'(dones), 32'd1);
        bcnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (done_v[0]) bcnt++;
        end
        chk("a5_extra_done", 32'(bcnt), 32'd0);

        // Parity even: 8'h07 -> parity 1
        start_frame(1, 8'h07);
        run_frame(1, 1'b0, -1, -1, bits, ticks, dones, aborted);
        chk("par_even_bits", 32'(bits), 32'h60E);
        chk("par_even_ticks", 32'(ticks), 32'd176);
        chk("par_even_done", 32'(dones), 32'd1);

        // Parity odd: 8'h07 -> parity 0
        start_frame(2, 8'h07);
        run_frame(2, 1'b0, -1, -1, bits, ticks, dones, aborted);
        chk("par_odd_bits", 32'(bits), 32'h40E);
        chk("par_odd_ticks", 32'(ticks), 32'd176);

        // Request with 8'hFF during data bit 2 of an 8'h3C frame is ignored
        start_frame(0, 8'h3C);
        run_frame(0, 1'b0, OS * 3 + OS / 2, -1, bits, ticks, dones, aborted);
        chk("ign_data", 32'(bits[8:1]), 32'h3C);
        chk("ign_ticks", 32'(ticks), 32'd160);
        bcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy_v[0]) bcnt++;
        end
        chk("ign_no_second", 32'(bcnt), 32'd0);

        // Abort during data bit 3
        start_frame(0, 8'hC3);
        run_frame(0, 1'b0, -1, OS * 4 + OS / 2, bits, ticks, dones, aborted);
        chk("abort_taken", 32'(aborted), 32'd1);
        bcnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_v[0] || busy_v[0]) bcnt++;
        end
        chk("abort_no_done", 32'(bcnt), 32'd0);
        rst = 1'b1;
        start_frame(0, 8'h55);
        run_frame(0, 1'b0, -1, -1, bits, ticks, dones, aborted);
        chk("post_abort_bits", 32'(bits[9:0]), 32'h2AA);
        chk("post_abort_done", 32'(dones), 32'd1);

        // Back-to-back with tx_start held; din change mid-frame must not leak
        @(negedge clk);
        din = 8'h01;
        tx_start[0] = 1'b1;
        @(negedge clk);
        din = 8'h80;
        run_frame(0, 1'b1, -1, -1, bits, ticks, dones, aborted);
        chk("b2b_first_data", 32'(bits[8:1]), 32'h01);
        chk("b2b_done_cycle", 32'(done_v[0]), 32'd1);
        chk("b2b_done_tx", 32'(tx_v[0]), 32'd1);
        @(negedge clk);
        chk("b2b_restart_busy", 32'(busy_v[0]), 32'd1);
        chk("b2b_restart_tx", 32'(tx_v[0]), 32'd0);
        run_frame(0, 1'b0, -1, -1, bits, ticks, dones, aborted);
        chk("b2b_second_data", 32'(bits[8:1]), 32'h80);
        chk("b2b_second_done", 32'(dones), 32'd1);

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
